// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN pixel pipeline.
package cnn_pkg;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 480;
    localparam int IMG_H  = 270;

    typedef logic signed [DATA_W-1:0] pix_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } lb_state_t;
endpackage

// File: rtl/line_ram_rf.sv
// Single-clock simple dual-port RAM, read-first: a read of the address being
// written in the same cycle returns the previous contents.
module line_ram_rf #(
    parameter int DEPTH = 480,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on storage or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_line_buffer_3row.sv
// Three-row line buffer: presents column c of rows r-2, r-1, r to the 3x3
// multiply stage once two full rows of the frame are buffered.
module conv_line_buffer_3row #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] din_1,
    output logic [DATA_W-1:0] din_2,
    output logic [DATA_W-1:0] din_3,
    output logic [COL_W-1:0]  col_out,
    output logic              eol_out,
    output logic              eof_out
);
    import cnn_pkg::*;

    localparam int ROW_W  = $clog2(IMG_H);
    localparam int STAGES = 1;

    lb_state_t         state, state_nxt, state_eff;
    logic [COL_W-1:0]  col_cnt, col_nxt, cur_col;
    logic [ROW_W-1:0]  row_cnt, row_nxt, cur_row;
    logic              produce, row_end, frame_end;

    // Stage 1: accepted pixel captured alongside the synchronous RAM reads.
    logic              wr_en_q;
    logic [COL_W-1:0]  col_q;
    logic [DATA_W-1:0] pix_q;
    logic              eol_q, eof_q;
    logic [STAGES:0]   vld_pipe;
    logic [DATA_W-1:0] rd_a, rd_b;

    always_comb begin
        cur_col   = sof ? '0 : col_cnt;
        cur_row   = sof ? '0 : row_cnt;
        state_eff = sof ? FILL : state;
        row_end   = (cur_col == COL_W'(IMG_W - 1));
        frame_end = row_end && (cur_row == ROW_W'(IMG_H - 1));
        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        state_nxt = state;
        produce   = 1'b0;
        if (pix_valid) begin
            col_nxt   = row_end ? '0 : cur_col + 1'b1;
            row_nxt   = !row_end ? cur_row : (frame_end ? '0 : cur_row + 1'b1);
            state_nxt = state_eff;
            case (state_eff)
                FILL: if (cur_row == ROW_W'(2) && cur_col == '0) begin
                    state_nxt = RUN;
                    produce   = 1'b1;
                end
                RUN: begin
                    produce = 1'b1;
                    if (frame_end) state_nxt = FILL;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q  <= 1'b0;
            col_q    <= '0;
            pix_q    <= '0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            vld_pipe <= '0;
        end else begin
            wr_en_q  <= pix_valid;
            if (pix_valid) begin
                col_q <= cur_col;
                pix_q <= pix_in;
            end
            eol_q    <= produce && row_end;
            eof_q    <= produce && frame_end;
            vld_pipe <= {vld_pipe[STAGES-1:0], produce};
        end
    end

    // Writes land one cycle after the read of the same column, so LB_B takes
    // LB_A's old word straight from its read port. The only same-address
    // overlap is a sof pixel at column 0, whose rows are rewritten before use.
    line_ram_rf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(COL_W)) u_lb_a (
        .clk   (clk),
        .we    (wr_en_q),
        .waddr (col_q),
        .wdata (pix_q),
        .re    (pix_valid),
        .raddr (cur_col),
        .rdata (rd_a)
    );

    line_ram_rf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(COL_W)) u_lb_b (
        .clk   (clk),
        .we    (wr_en_q),
        .waddr (col_q),
        .wdata (rd_a),
        .re    (pix_valid),
        .raddr (cur_col),
        .rdata (rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_1   <= '0;
            din_2   <= '0;
            din_3   <= '0;
            col_out <= '0;
            eol_out <= 1'b0;
            eof_out <= 1'b0;
        end else begin
            din_1   <= rd_b;
            din_2   <= rd_a;
            din_3   <= pix_q;
            col_out <= col_q;
            eol_out <= eol_q;
            eof_out <= eof_q;
        end
    end

    assign valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_conv_line_buffer_3row.sv
// Bench for conv_line_buffer_3row on a 4x4 image: an image-array model predicts
// every output cycle, plus literal checks on captured outputs per scenario.
module tb_conv_line_buffer_3row;
    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sof, pix_valid;
    logic [7:0] pix_in;
    logic       valid_out, eol_out, eof_out;
    logic [7:0] din_1, din_2, din_3;
    logic [1:0] col_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       vld;
        logic [7:0] d1, d2, d3;
        logic [1:0] col;
        logic       eol, eof;
    } exp_t;

    exp_t pend, expo;
    exp_t got[$];
    logic [7:0] img [H][W];
    int mr, mc;

    conv_line_buffer_3row #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid),
        .pix_in(pix_in), .valid_out(valid_out), .din_1(din_1), .din_2(din_2),
        .din_3(din_3), .col_out(col_out), .eol_out(eol_out), .eof_out(eof_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted pixel at row r >= 2 of the current frame yields
    // (img[r-2][c], img[r-1][c], pixel) one cycle after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mr   <= 0;
            mc   <= 0;
            pend <= '0;
            expo <= '0;
        end else begin : mdl
            int r, c;
            exp_t e;
            e = '0;
            expo <= pend;
            if (pix_valid) begin
                r = sof ? 0 : mr;
                c = sof ? 0 : mc;
                if (r >= 2) begin
                    e.vld = 1'b1;
                    e.d1  = img[r-2][c];
                    e.d2  = img[r-1][c];
                    e.d3  = pix_in;
                    e.col = 2'(c);
                    e.eol = (c == W-1);
                    e.eof = (c == W-1) && (r == H-1);
                end
                img[r][c] <= pix_in;
                if (c == W-1) begin
                    mc <= 0;
                    mr <= (r == H-1) ? 0 : r + 1;
                end else begin
                    mc <= c + 1;
                    mr <= r;
                end
            end
            pend <= e;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", int'(valid_out), 0);
            chk("rst_din", int'({din_1, din_2, din_3}), 0);
            chk("rst_flags", int'({col_out, eol_out, eof_out}), 0);
        end else begin
            chk("valid_out", int'(valid_out), int'(expo.vld));
            if (expo.vld) begin
                chk("din_1", int'(din_1), int'(expo.d1));
                chk("din_2", int'(din_2), int'(expo.d2));
                chk("din_3", int'(din_3), int'(expo.d3));
                chk("col_out", int'(col_out), int'(expo.col));
                chk("eol_out", int'(eol_out), int'(expo.eol));
                chk("eof_out", int'(eof_out), int'(expo.eof));
            end
            if (valid_out)
                got.push_back('{1'b1, din_1, din_2, din_3, col_out, eol_out, eof_out});
        end
    end

    task automatic px(input logic s, input logic [7:0] p);
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = s;
        pix_in    = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    // npix limits how many pixels are sent; use_sof marks the first pixel.
    task automatic frame(input logic [7:0] off, input bit gaps, input bit use_sof, input int npix);
        for (int i = 0; i < npix; i++) begin
            px(use_sof && i == 0, 8'(off + (i / W) * 16 + (i % W)));
            if (gaps) idle(1);
        end
    endtask

    task automatic pin_out(input string nm, input int idx, input int e1, input int e2, input int e3);
        if (idx >= got.size()) begin
            chk({nm, "_missing"}, got.size(), idx + 1);
        end else begin
            chk({nm, "_d1"}, int'(got[idx].d1), e1);
            chk({nm, "_d2"}, int'(got[idx].d2), e2);
            chk({nm, "_d3"}, int'(got[idx].d3), e3);
        end
    endtask

    initial begin
        int b;
        rst_n = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Continuous frame
        b = got.size();
        frame(8'h00, 0, 1, W*H);
        idle(3);
        chk("s1_count", got.size() - b, 8);
        pin_out("s1_first", b, 'h00, 'h10, 'h20);
        if (got.size() > b) chk("s1_first_col", int'(got[b].col), 0);
        pin_out("s1_last", b + 7, 'h13, 'h23, 'h33);
        if (got.size() > b + 7) chk("s1_last_eol_eof", int'({got[b+7].eol, got[b+7].eof}), 3);

        // Bubbles between every pixel
        b = got.size();
        frame(8'h00, 1, 1, W*H);
        idle(3);
        chk("s2_count", got.size() - b, 8);
        for (int i = 0; i < 8; i++)
            pin_out("s2_seq", b + i, (i/4)*16 + i%4, (i/4+1)*16 + i%4, (i/4+2)*16 + i%4);

        // Back-to-back frames
        b = got.size();
        frame(8'h00, 0, 1, W*H);
        frame(8'h40, 0, 1, W*H);
        idle(3);
        chk("s3_count", got.size() - b, 16);
        pin_out("s3_f2_first", b + 8, 'h40, 'h50, 'h60);

        // sof at row 2 col 1 abandons the partial frame
        b = got.size();
        frame(8'h40, 0, 1, 9);
        frame(8'h00, 0, 1, W*H);
        idle(3);
        chk("s4_count", got.size() - b, 9);
        pin_out("s4_old", b, 'h40, 'h50, 'h60);
        pin_out("s4_new_first", b + 1, 'h00, 'h10, 'h20);

        // Async reset at row 3 col 2, restart without sof
        frame(8'h00, 0, 1, 14);
        @(negedge clk);
        pix_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_valid", int'(valid_out), 0);
        chk("s5_async_din3", int'(din_3), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b = got.size();
        frame(8'h00, 0, 0, 8);
        idle(2);
        chk("s5_after8", got.size() - b, 0);
        frame(8'h20, 0, 0, 8);
        idle(3);
        chk("s5_count", got.size() - b, 8);
        pin_out("s5_first", b, 'h00, 'h10, 'h20);

        // Signed extremes in alternating rows
        b = got.size();
        for (int i = 0; i < W*H; i++)
            px(i == 0, ((i / W) % 2 == 0) ? 8'h80 : 8'h7F);
        idle(3);
        chk("s6_count", got.size() - b, 8);
        pin_out("s6_first", b, 'h80, 'h7F, 'h80);
        pin_out("s6_last", b + 7, 'h7F, 'h80, 'h7F);
        if (got.size() > b) chk("s6_signed", int'($signed(got[b].d1)), -128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_line_buffer_3row.md
# conv_line_buffer_3row

Streaming 3-row line buffer that feeds the 3×3 INT8 convolution multiply stage (`cal_multi_3INT8`). It accepts a raster-order pixel stream, one INT8 pixel per valid cycle. It presents the same column of three consecutive rows on `din_1` (oldest row), `din_2` and `din_3` (newest row), and raises `valid_out` only once two full rows are buffered. It is the producer end of the `din_1/din_2/din_3`/`valid_in` interface that the multiply stage consumes.

## Interface
- `IMG_W`, 480, pixels per row (≥ 3).
- `IMG_H`, 270, rows per frame (≥ 3).
- `DATA_W`, 8, pixel width (signed two's complement).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sof` input 1: start-of-frame. Qualified by `pix_valid` and marks the first pixel of a frame.
- `pix_valid` input 1: pixel strobe. The pixel is accepted on every rising clk edge where this is high.
- `pix_in` input DATA_W: incoming pixel, raster order.
- `valid_out` output 1: `din_*` hold a valid column. Drives `valid_in` of the multiply stage.
- `din_1` output DATA_W: pixel at (row r-2, col c).
- `din_2` output DATA_W: pixel at (row r-1, col c).
- `din_3` output DATA_W: pixel at (row r, col c).
- `col_out` output clog2(IMG_W): column index c of the current output.
- `eol_out` output 1: high with the last column (c = IMG_W-1) of an output row.
- `eof_out` output 1: high with the final output of the frame (r = IMG_H-1, c = IMG_W-1).

## Operation
- Counters: `col_cnt` runs 0..IMG_W-1 and `row_cnt` runs 0..IMG_H-1. Both advance only on accepted pixels. `col_cnt` wraps to 0 at IMG_W-1 and then `row_cnt` increments. After (IMG_H-1, IMG_W-1), both wrap to 0.
- `sof` with `pix_valid` forces the accepted pixel to be (row 0, col 0), overriding the counters. This applies mid-frame too: the partial frame is abandoned and any fill progress is discarded.
- Two line memories, LB_A and LB_B, each IMG_W × DATA_W.
  - LB_A holds the previous row.
  - LB_B holds the row before that.
  - On each accepted pixel at column c: LB_B[c] ← LB_A[c] (old value) and LB_A[c] ← `pix_in`.
- FSM (two states):
  - FILL (reset state): rows 0 and 1 are being written; no output.
  - RUN: entered when the first pixel of row 2 is accepted. Each accepted pixel produces one output.
  - RUN → FILL: after the last pixel of the frame, or on `sof`. A `sof` pixel is itself processed as row 0 in FILL.
- Output per accepted pixel in RUN: `din_3` = `pix_in`, `din_2` = LB_A[c], `din_1` = LB_B[c], all values from before this cycle's write.
- Bubbles (`pix_valid` low): counters, memories and FSM hold. `valid_out` is low for the corresponding output cycle.
- Outputs per frame: exactly (IMG_H-2) × IMG_W with `valid_out` high. Border padding is not generated.
- No arithmetic beyond the counters. Pixels pass through bit-exact, so sign is preserved.

## Timing
- Latency: 1 cycle. A pixel accepted at edge k produces `valid_out`/`din_*`/`col_out`/`eol_out`/`eof_out` that are valid after edge k+1.
- Throughput: 1 pixel per clock, with no backpressure; the multiply stage always accepts.
- Read-during-write to the same LB address must return the old data (read-first behaviour). The implementation delays or aligns the write data internally to meet this.
- Reset values:
  - `valid_out`, `eol_out` and `eof_out` are 0.
  - `din_1`, `din_2`, `din_3` and `col_out` are 0.
  - The FSM is in FILL and the counters are 0.
  - LB contents are not reset (don't care).
- Reset mid-frame: outputs go to their reset values immediately (asynchronously). The next accepted pixel is treated as (0,0) whether or not `sof` is asserted.
- `sof` together with a counter wrap in the same cycle: `sof` wins. The result is (0,0) with no extra output.
- `eof_out` and `eol_out` are single-cycle pulses coincident with `valid_out`.

## Structure
- Shared package `cnn_pkg`: `DATA_W`, `IMG_W` and `IMG_H` defaults, the `pix_t` signed DATA_W typedef, and the FSM state enum {FILL, RUN}.
- One sub-module, `line_ram_rf`: a single-clock, read-first, simple dual-port RAM (depth and width parameterised). It is instantiated twice, as LB_A and LB_B, and must map to block RAM.
- The top level holds the counters, FSM and output registers.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, with `pix_in` = row×16 + col.
- Continuous frame, `sof` on the first pixel: 8 outputs with `valid_out` high. The first output is din_1=0x00, din_2=0x10, din_3=0x20, col_out=0. The last output is 0x13/0x23/0x33 with eol_out=1 and eof_out=1.
- Same frame with `pix_valid` toggling 1,0,1,0: identical 8 output values in the same order, with `valid_out` low in the bubble cycles.
- Two back-to-back frames, the second using values +0x40: the second frame's first output is 0x40/0x50/0x60. No output during its rows 0–1.
- `sof` asserted at row 2, col 1 of a frame: no further outputs until row 2 of the new frame. The new frame's first output is 0x00/0x10/0x20 (new data).
- `rst_n` pulsed low at row 3, col 2: outputs are 0 during reset. The next pixel without `sof` is treated as (0,0). Outputs resume only after 8 accepted pixels.
- Signed pass-through with pixels set to -128 (0x80) and 127 (0x7F) in alternating rows: `din_*` reproduce these values exactly with no sign extension error.
